riscv_dmem_responder: RTL and testbench
=======================================

Name: riscv_dmem_responder

Overview:
Data-memory responder serving the single-cycle RISC-V core's load/store port via a valid/ready request/response handshake.
- Adds configurable wait states, byte enables, alignment and range checking.
- Provides an init-driven sequential clear of the array.
- Sits between the core's data port (mem_addr / mem_wd / mem_we) and the storage array. It replaces the zero-latency data memory when the core is stalled on memory.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two.
WAIT_CYCLES, 2, extra cycles between request acceptance and response; range 0..15.
IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
init  input  1  request to clear the whole array; level-sampled in IDLE
init_busy  output  1  high while the clear sweep runs
req_valid  input  1  request present
req_ready  output  1  responder accepts request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit i covers bits 8i+7:8i
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, wait counter=0, init index=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=0.
  - Array contents are not reset.
  - req_ready rises on the first clock edge after rst is released.
- States: IDLE, INIT, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - If init=1: go to INIT. init has priority over a simultaneous req_valid, which is not accepted.
  - Else on req_valid & req_ready: capture we/addr/wdata/be.
    - err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH).
    - Go to WAIT with counter=WAIT_CYCLES, or straight to the access edge if WAIT_CYCLES=0.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0, perform the access and go to RESP.
- Access edge:
  - Store with err=0: write enabled bytes of word addr[IDX_W+1:2]; rsp_rdata=0.
  - Load with err=0: rsp_rdata = array word; byte enables ignored.
  - err=1: no write, rsp_rdata=0, rsp_err=1.
  - req_be=0 store: no write, err as computed.
- Latency: request accepted at edge t0 → rsp_valid=1 registered at edge t0+WAIT_CYCLES+1.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0, go to IDLE.
  - A new request can be accepted no earlier than the following edge; there is no overlap.
- INIT:
  - req_ready=0, init_busy=1.
  - Writes 0 to index 0..DEPTH-1, one word per cycle, for DEPTH cycles.
  - After the last write: init_busy=0, go to IDLE.
  - init asserted during WAIT/RESP is ignored until IDLE. If still high there, it is honoured; holding init high re-runs the clear.
- Reset mid-WAIT aborts the access; a pending store is not committed.
- Reset mid-INIT leaves the array partially cleared. Contents are undefined until the next init.
- Index arithmetic: unsigned; the range check uses the full 30-bit word address, never the truncated index.

Decomposition:
- Package riscv_dmem_pkg:
  - state enum (IDLE, INIT, WAIT, RESP).
  - BE_W=4 and DATA_W=32 constants.
  - helper function computing the byte-merge mask from be.
- Sub-module riscv_dmem_array:
  - single-port synchronous RAM, DEPTH x 32.
  - per-byte write enable, registered read.
  - no reset.
- FSM, wait counter, init index, checks and response registers live in the top module.

Test Plan:
1. Release rst. Store 0xDEADBEEF at 0x10 with be=4'hF, then load 0x10. Expect: rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 3 edges after acceptance (WAIT_CYCLES=2).
2. Store 0x11223344 at 0x10 with be=4'b0101, then load 0x10. Expect: 0xDE22BE44.
3. Load 0x13. Expect: rsp_err=1, rdata=0. Store 0xFFFFFFFF at 0x1000 (DEPTH=1024). Expect: rsp_err=1; loading 0x0 still returns its prior value.
4. Hold rsp_ready=0 for 5 cycles during RESP. Expect: rsp_valid, rdata and err stable, req_ready=0 throughout; the next request is accepted on the edge after the handshake edge.
5. Pulse init in IDLE together with req_valid. Expect: request not accepted, init_busy=1 for exactly 1024 cycles, req_ready=0 meanwhile; then loading 0x10 returns 0x00000000.
6. Store 0xCAFEF00D at 0x20; assert rst one cycle after acceptance. Expect: all outputs at reset values immediately; after release, loading 0x20 returns the previous contents, not 0xCAFEF00D.

Source files
------------

// File: rtl/riscv_dmem_pkg.sv
// Shared types and helpers for the RISC-V data-memory responder.
// Holds the FSM state encoding, data/byte-enable widths and the byte-merge mask.
package riscv_dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmem_state_e;

  // Expand each byte-enable bit over its 8-bit lane.
  function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = {DATA_W{1'b0}};
    for (int i = 0; i < BE_W; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/riscv_dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
// Contents are never reset; a read only updates the output register when no byte is written.
module riscv_dmem_array
  import riscv_dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;
  logic [DATA_W-1:0] mask_s;

  assign mask_s = be_mask(we);
  assign rdata  = rdata_r;

  // Byte-merged write or registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
        mem_r[idx] <= (mem_r[idx] & ~mask_s) | (wdata & mask_s);
      end else begin
        rdata_r <= mem_r[idx];
      end
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Valid/ready data-memory responder for the RISC-V core: wait states, byte enables,
// alignment/range checking and an init-driven sequential clear of the storage array.
module riscv_dmem_responder
  import riscv_dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  output logic              init_busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_e       state_r, state_nx;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  init_idx_r;
  logic              we_r, err_r;
  logic [IDX_W-1:0]  addr_idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic [BE_W-1:0]   be_r;
  logic              req_ready_r, rsp_valid_r, rsp_err_r, init_busy_r;
  logic [DATA_W-1:0] rsp_rdata_r;

  logic              accept_s, access_s, init_last_s, req_err_s;
  logic              ram_en_s;
  logic [BE_W-1:0]   ram_we_s;
  logic [IDX_W-1:0]  ram_idx_s;
  logic [DATA_W-1:0] ram_wdata_s, ram_rdata_s;

  assign accept_s    = (state_r == IDLE) & ~init & req_valid & req_ready_r;
  assign access_s    = (state_r == WAIT) & (cnt_r == {CNT_W{1'b0}});
  assign init_last_s = (init_idx_r == IDX_W'(DEPTH - 1));
  // Range check runs on the full word address so high bits cannot alias into the array.
  assign req_err_s   = (req_addr[1:0] != 2'b00) | (req_addr[31:2] >= 30'(DEPTH));

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign init_busy = init_busy_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; init wins over a simultaneous request in IDLE.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (init) begin
          state_nx = INIT;
        end else if (accept_s) begin
          state_nx = WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      INIT: begin
        if (init_last_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = INIT;
        end
      end
      WAIT: begin
        if (access_s) begin
          state_nx = RESP;
        end else begin
          state_nx = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = RESP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, wait counter, clear index and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= {CNT_W{1'b0}};
      init_idx_r  <= {IDX_W{1'b0}};
      we_r        <= 1'b0;
      err_r       <= 1'b0;
      addr_idx_r  <= {IDX_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      be_r        <= {BE_W{1'b0}};
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
      init_busy_r <= 1'b0;
    end else begin
      req_ready_r <= (state_nx == IDLE);
      case (state_r)
        IDLE: begin
          if (init) begin
            init_idx_r  <= {IDX_W{1'b0}};
            init_busy_r <= 1'b1;
          end else if (accept_s) begin
            we_r       <= req_we;
            err_r      <= req_err_s;
            addr_idx_r <= req_addr[IDX_W+1:2];
            wdata_r    <= req_wdata;
            be_r       <= req_be;
            cnt_r      <= CNT_W'(WAIT_CYCLES);
          end
        end
        INIT: begin
          init_idx_r <= init_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          if (init_last_s) begin
            init_busy_r <= 1'b0;
          end
        end
        WAIT: begin
          if (access_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_r;
            rsp_rdata_r <= (we_r | err_r) ? {DATA_W{1'b0}} : ram_rdata_s;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // RAM port steering. Loads read on the accept edge; nothing else touches the
  // array during WAIT, so the registered read still reflects the access edge.
  always_comb begin
    ram_en_s    = 1'b0;
    ram_we_s    = {BE_W{1'b0}};
    ram_idx_s   = {IDX_W{1'b0}};
    ram_wdata_s = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (accept_s & ~req_we) begin
          ram_en_s  = 1'b1;
          ram_idx_s = req_addr[IDX_W+1:2];
        end else begin
          ram_en_s  = 1'b0;
        end
      end
      INIT: begin
        ram_en_s    = 1'b1;
        ram_we_s    = {BE_W{1'b1}};
        ram_idx_s   = init_idx_r;
        ram_wdata_s = {DATA_W{1'b0}};
      end
      WAIT: begin
        if (access_s & we_r & ~err_r & (|be_r)) begin
          ram_en_s    = 1'b1;
          ram_we_s    = be_r;
          ram_idx_s   = addr_idx_r;
          ram_wdata_s = wdata_r;
        end else begin
          ram_en_s    = 1'b0;
        end
      end
      RESP:    ram_en_s = 1'b0;
      default: ram_en_s = 1'b0;
    endcase
  end

  riscv_dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .idx   (ram_idx_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed self-checking bench for riscv_dmem_responder (DEPTH=1024, WAIT_CYCLES=2).
module tb_riscv_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        init_busy;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .init_busy (init_busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; lat counts edges from acceptance to rsp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    int guard;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0; rdata = 32'd0; err = 1'b0; lat = -1;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 50);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    int          rdy_bad;

    rst = 1'b0; init = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rdata", rsp_rdata, 32'd0);
    check_val("rst_err", {31'd0, rsp_err}, 32'd0);
    check_val("rst_init_busy", {31'd0, init_busy}, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1 check_val("rel_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check_val("rel_ready_high", {31'd0, req_ready}, 32'd1);

    // Full-word store then load, latency 3 edges.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check_val("st1_rdata", rd, 32'd0);
    check_val("st1_err", {31'd0, er}, 32'd0);
    check_val("st1_lat", lat, 32'd3);
    do_req(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
    check_val("ld1_rdata", rd, 32'hDEADBEEF);
    check_val("ld1_err", {31'd0, er}, 32'd0);
    check_val("ld1_lat", lat, 32'd3);

    // Partial store merges lanes 0 and 2.
    do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
    do_req(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
    check_val("ld2_merge", rd, 32'hDE22BE44);

    // Zero-enable store writes nothing.
    do_req(1'b1, 32'h10, 32'h55555555, 4'h0, rd, er, lat);
    check_val("st_be0_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
    check_val("ld_be0", rd, 32'hDE22BE44);

    // Misaligned load and out-of-range store (0x1000 would alias word 0 if truncated).
    do_req(1'b1, 32'h0, 32'h0A0B0C0D, 4'hF, rd, er, lat);
    do_req(1'b0, 32'h13, 32'd0, 4'hF, rd, er, lat);
    check_val("mis_err", {31'd0, er}, 32'd1);
    check_val("mis_rdata", rd, 32'd0);
    do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check_val("oor_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h0, 32'd0, 4'h0, rd, er, lat);
    check_val("oor_noalias", rd, 32'h0A0B0C0D);
    check_val("ld0_err", {31'd0, er}, 32'd0);

    // Back-pressure in RESP with a follow-up request already pending.
    @(negedge clk);
    rsp_ready = 1'b0; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("bp_lat", n, 32'd3);
    repeat (5) begin
      @(posedge clk); #1;
      check_val("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("bp_rdata", rsp_rdata, 32'hDE22BE44);
      check_val("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    check_val("bp_err", {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_val("hs_valid_low", {31'd0, rsp_valid}, 32'd0);
    check_val("hs_ready_high", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("next_accepted", {31'd0, req_ready}, 32'd0);
    n = 1;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("next_lat_from_hs", n, 32'd4);
    check_val("next_rdata", rsp_rdata, 32'h0A0B0C0D);
    @(posedge clk); #1;

    // Init together with a request: init wins, sweep lasts DEPTH cycles.
    @(negedge clk);
    init = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    init = 1'b0; req_valid = 1'b0;
    check_val("init_busy_on", {31'd0, init_busy}, 32'd1);
    n = 1; rdy_bad = 0;
    if (req_ready) rdy_bad++;
    while (n < 3000) begin
      @(posedge clk); #1;
      if (init_busy) begin
        n++;
        if (req_ready) rdy_bad++;
      end else begin
        break;
      end
    end
    check_val("init_cycles", n, 32'd1024);
    check_val("init_ready_low", rdy_bad, 32'd0);
    check_val("init_done_ready", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
    check_val("init_clr_10", rd, 32'd0);
    do_req(1'b0, 32'h0, 32'd0, 4'h0, rd, er, lat);
    check_val("init_clr_0", rd, 32'd0);

    // Reset mid-WAIT aborts the pending store.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_val("abort_ready", {31'd0, req_ready}, 32'd0);
    check_val("abort_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("abort_rdata", rsp_rdata, 32'd0);
    check_val("abort_err", {31'd0, rsp_err}, 32'd0);
    check_val("abort_busy", {31'd0, init_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 32'h20, 32'd0, 4'h0, rd, er, lat);
    check_val("abort_nostore", rd, 32'd0);
    check_val("abort_ld_lat", lat, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
